clk_div_multi: RTL

Parametrised multi-channel clock-enable/clock generator clocked from the 100 MHz board clock. It produces NUM_CH independent square-wave outputs and matching one-cycle rising-edge tick pulses. Each channel has a terminal count that is programmable at run time, a per-channel enable, and a global phase-align restart. It feeds display refresh, debouncers and animation timers, replacing fixed single-rate dividers.

---
 rtl/clk_div_multi.sv | 81 ++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel tick pulses.
// Each channel toggles clk_out every term+1 enabled cycles.
module clk_div_multi #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_WIDTH    = 32,
    parameter int          CH_SEL_W     = 2,
    parameter int unsigned DEFAULT_TERM = 999999
) (
    input  logic                 basys_clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    enable,
    input  logic                 load,
    input  logic [CH_SEL_W-1:0]  ch_sel,
    input  logic [CNT_WIDTH-1:0] load_term,
    input  logic                 sync_all,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick
);

    localparam logic [CNT_WIDTH-1:0] TERM_RST = CNT_WIDTH'(DEFAULT_TERM);

    if (NUM_CH < 1 || NUM_CH > 16 || NUM_CH > (1 << CH_SEL_W)) begin : g_bad
        $error("clk_div_multi: NUM_CH out of range for CH_SEL_W");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_WIDTH-1:0] count_q;
        logic [CNT_WIDTH-1:0] count_d;
        logic [CNT_WIDTH-1:0] term_q;
        logic [CNT_WIDTH-1:0] term_d;
        logic                 out_q;
        logic                 out_d;
        logic                 tick_q;
        logic                 tick_d;
        logic                 hit;

        // Out-of-range ch_sel never matches any instantiated channel.
        assign hit = load && (ch_sel == CH_SEL_W'(c));

        always_comb begin
            count_d = count_q;
            term_d  = term_q;
            out_d   = out_q;
            tick_d  = 1'b0;
            if (sync_all) begin
                count_d = '0;
                out_d   = 1'b0;
            end else if (hit) begin
                term_d  = load_term;
                count_d = '0;
                out_d   = 1'b0;
            end else if (!enable[c]) begin
                count_d = count_q;
            end else if (count_q == term_q) begin
                count_d = '0;
                out_d   = ~out_q;
                tick_d  = ~out_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        always_ff @(posedge basys_clk or posedge reset) begin
            if (reset) begin
                count_q <= '0;
                term_q  <= TERM_RST;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                count_q <= count_d;
                term_q  <= term_d;
                out_q   <= out_d;
                tick_q  <= tick_d;
            end
        end

        assign clk_out[c] = out_q;
        assign tick[c]    = tick_q;
    end

endmodule
